// File: rtl/lfsr_pkg.sv
// Shared constants and a reusable next-state function for Galois-style CRC/LFSR engines.
package lfsr_pkg;

  localparam int LFSR_DEFAULT_WIDTH = 512;
  localparam int DATA_DEFAULT_WIDTH = 33;

  // x^512 + x^510 + x^507 + x^504 + 1, with the x^512 term implicit
  localparam logic [LFSR_DEFAULT_WIDTH-1:0] LFSR_POLY_512 =
      (512'd1 << 510) | (512'd1 << 507) | (512'd1 << 504) | 512'd1;

  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

  // Folds one default-width word into a default-width state, MSB of the data first
  function automatic logic [LFSR_DEFAULT_WIDTH-1:0] lfsr_next(
    input logic [LFSR_DEFAULT_WIDTH-1:0] state,
    input logic [DATA_DEFAULT_WIDTH-1:0] data,
    input logic [LFSR_DEFAULT_WIDTH-1:0] poly
  );
    logic [LFSR_DEFAULT_WIDTH-1:0] s;
    logic                          fb;
    s = state;
    for (int i = DATA_DEFAULT_WIDTH - 1; i >= 0; i--) begin
      fb = s[LFSR_DEFAULT_WIDTH-1] ^ data[i];
      s  = s << 1;
      if (fb) s = s ^ poly;
    end
    return s;
  endfunction

endpackage

// File: rtl/lfsr_crc_step.sv
// Combinational next-state for the CRC/LFSR: all DATA_WIDTH bit-steps unrolled, MSB first.
module lfsr_crc_step
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH = LFSR_DEFAULT_WIDTH,
  parameter int                    DATA_WIDTH = DATA_DEFAULT_WIDTH,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = LFSR_POLY_512
) (
  input  logic [LFSR_WIDTH-1:0] state_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  logic [LFSR_WIDTH-1:0] s;
  logic                  fb;

  // Shift one data bit at a time into the register, feeding back the polynomial when the XORed top bit is set
  always_comb begin
    s  = state_in;
    fb = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = s[LFSR_WIDTH-1] ^ data_in[i];
      s  = s << 1;
      if (fb) s = s ^ LFSR_POLY;
    end
  end

  assign state_out = s;

endmodule

// File: rtl/lfsr_crc.sv
// Registered CRC/LFSR engine: folds one DATA_WIDTH-bit word per valid cycle into the state.
module lfsr_crc
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH = LFSR_DEFAULT_WIDTH,
  parameter int                    DATA_WIDTH = DATA_DEFAULT_WIDTH,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = LFSR_POLY_512,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT  = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic [LFSR_WIDTH-1:0] crc_out
);

  logic [LFSR_WIDTH-1:0] state;
  logic [LFSR_WIDTH-1:0] next_state;

  lfsr_crc_step #(
    .LFSR_WIDTH (LFSR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LFSR_POLY  (LFSR_POLY)
  ) u_step (
    .state_in  (state),
    .data_in   (data_in),
    .state_out (next_state)
  );

  // Reset wins over valid; otherwise take the folded value only on qualified cycles
  always_ff @(posedge clk) begin
    if (rst)                state <= LFSR_INIT;
    else if (data_in_valid) state <= next_state;
  end

  assign crc_out = state;

endmodule

// File: tb/tb_lfsr_crc.sv
// Self-checking bench for lfsr_crc across several configurations, using a polynomial-division reference.
module tb_lfsr_crc;
  import lfsr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [32:0]  d_def;
  logic         v_def;
  logic [511:0] crc_def;

  logic [7:0]   d_c32;
  logic         v_c32;
  logic [31:0]  crc_c32;

  logic [7:0]   d_c16;
  logic         v_c16;
  logic [15:0]  crc_c16;

  logic [31:0]  d_c32w;
  logic         v_c32w;
  logic [31:0]  crc_c32w;

  logic [0:0]   d_zero;
  logic         v_zero;
  logic [511:0] crc_zero;

  int checks = 0;
  int errors = 0;

  localparam logic [511:0] ONES512 = '1;

  lfsr_crc u_def (
    .clk(clk), .rst(rst), .data_in(d_def), .data_in_valid(v_def), .crc_out(crc_def)
  );

  lfsr_crc #(.LFSR_WIDTH(32), .DATA_WIDTH(8), .LFSR_POLY(CRC32_POLY), .LFSR_INIT(32'hFFFFFFFF)) u_c32 (
    .clk(clk), .rst(rst), .data_in(d_c32), .data_in_valid(v_c32), .crc_out(crc_c32)
  );

  lfsr_crc #(.LFSR_WIDTH(16), .DATA_WIDTH(8), .LFSR_POLY(CRC16_CCITT_POLY), .LFSR_INIT(16'hFFFF)) u_c16 (
    .clk(clk), .rst(rst), .data_in(d_c16), .data_in_valid(v_c16), .crc_out(crc_c16)
  );

  lfsr_crc #(.LFSR_WIDTH(32), .DATA_WIDTH(32), .LFSR_POLY(CRC32_POLY), .LFSR_INIT(32'hFFFFFFFF)) u_c32w (
    .clk(clk), .rst(rst), .data_in(d_c32w), .data_in_valid(v_c32w), .crc_out(crc_c32w)
  );

  lfsr_crc #(.LFSR_WIDTH(512), .DATA_WIDTH(1), .LFSR_POLY(LFSR_POLY_512), .LFSR_INIT('0)) u_zero (
    .clk(clk), .rst(rst), .data_in(d_zero), .data_in_valid(v_zero), .crc_out(crc_zero)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference: new state = (S * x^k + D * x^w) mod P, by long division over GF(2)
  function automatic logic [511:0] ref_fold(input logic [511:0] s, input logic [511:0] d,
                                            input int w, input int k, input logic [511:0] poly);
    logic [1023:0] r;
    logic [1023:0] p;
    logic [1023:0] dm;
    dm = {512'b0, d} & ((1024'd1 << k) - 1);
    r  = ({512'b0, s} << k) ^ (dm << w);
    p  = {512'b0, poly} | (1024'd1 << w);
    for (int j = 1023; j >= w; j--) begin
      if (r[j]) r = r ^ (p << (j - w));
    end
    r = r & ((1024'd1 << w) - 1);
    return r[511:0];
  endfunction

  function automatic logic [7:0] msg_byte(input int i);
    return 8'(8'h31 + i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    v_def = 1'b0; v_c32 = 1'b0; v_c16 = 1'b0; v_c32w = 1'b0; v_zero = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] r;
    $display("[TB] test_reset");
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      r = {$urandom, $urandom};
      d_def = r[32:0];
      v_def = 1'b1;
      tick();
      checks++;
      if (crc_def !== ONES512) begin
        errors++;
        $display("[TB] FAIL reset_load: got %h expected %h", crc_def, ONES512);
      end
    end
    rst = 1'b0;
    v_def = 1'b0;
    for (int c = 0; c < 20; c++) begin
      r = {$urandom, $urandom};
      d_def = r[32:0];
      tick();
      checks++;
      if (crc_def !== ONES512) begin
        errors++;
        $display("[TB] FAIL reset_hold: got %h expected %h", crc_def, ONES512);
      end
    end
  endtask

  task automatic test_crc32();
    logic [511:0] m;
    $display("[TB] test_crc32");
    do_reset();
    m = 512'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      d_c32 = msg_byte(i);
      v_c32 = 1'b1;
      tick();
      m = ref_fold(m, {504'b0, msg_byte(i)}, 32, 8, {480'b0, CRC32_POLY});
      checks++;
      if (crc_c32 !== m[31:0]) begin
        errors++;
        $display("[TB] FAIL crc32_step%0d: got %h expected %h", i, crc_c32, m[31:0]);
      end
    end
    v_c32 = 1'b0;
    tick();
    checks++;
    if (crc_c32 !== 32'h0376E6E7) begin
      errors++;
      $display("[TB] FAIL crc32_final: got %h expected %h", crc_c32, 32'h0376E6E7);
    end
  endtask

  task automatic test_crc16_bubbles();
    logic [511:0] m;
    int           gaps;
    $display("[TB] test_crc16_bubbles");
    do_reset();
    m = 512'hFFFF;
    for (int i = 0; i < 9; i++) begin
      d_c16 = msg_byte(i);
      v_c16 = 1'b1;
      tick();
      m = ref_fold(m, {504'b0, msg_byte(i)}, 16, 8, {496'b0, CRC16_CCITT_POLY});
      checks++;
      if (crc_c16 !== m[15:0]) begin
        errors++;
        $display("[TB] FAIL crc16_step%0d: got %h expected %h", i, crc_c16, m[15:0]);
      end
      gaps = int'($urandom_range(1, 3));
      for (int g = 0; g < gaps; g++) begin
        v_c16 = 1'b0;
        d_c16 = 8'($urandom);
        tick();
        checks++;
        if (crc_c16 !== m[15:0]) begin
          errors++;
          $display("[TB] FAIL crc16_bubble%0d: got %h expected %h", i, crc_c16, m[15:0]);
        end
      end
    end
    checks++;
    if (crc_c16 !== 16'h29B1) begin
      errors++;
      $display("[TB] FAIL crc16_final: got %h expected %h", crc_c16, 16'h29B1);
    end
  endtask

  task automatic test_width_equiv();
    logic [511:0] mw;
    $display("[TB] test_width_equiv");
    do_reset();
    mw = ref_fold(512'hFFFFFFFF, 512'h31323334, 32, 32, {480'b0, CRC32_POLY});
    d_c32w = 32'h31323334;
    v_c32w = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_c32 = msg_byte(i);
      v_c32 = 1'b1;
      tick();
      v_c32w = 1'b0;
    end
    v_c32 = 1'b0;
    tick();
    checks++;
    if (crc_c32w !== mw[31:0]) begin
      errors++;
      $display("[TB] FAIL width_wide: got %h expected %h", crc_c32w, mw[31:0]);
    end
    checks++;
    if (crc_c32 !== mw[31:0]) begin
      errors++;
      $display("[TB] FAIL width_narrow: got %h expected %h", crc_c32, mw[31:0]);
    end
  endtask

  task automatic test_random_default();
    logic [511:0] m;
    logic [63:0]  r;
    $display("[TB] test_random_default");
    do_reset();
    m = ONES512;
    for (int c = 0; c < 60; c++) begin
      r = {$urandom, $urandom};
      d_def = r[32:0];
      v_def = 1'($urandom);
      tick();
      if (v_def) m = ref_fold(m, {479'b0, r[32:0]}, 512, 33, LFSR_POLY_512);
      checks++;
      if (crc_def !== m) begin
        errors++;
        $display("[TB] FAIL random%0d: got %h expected %h", c, crc_def, m);
      end
    end
    v_def = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [511:0] m;
    logic [511:0] exp_q [20];
    logic [32:0]  addr;
    logic [63:0]  r;
    $display("[TB] test_reset_midstream");
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      m = ONES512;
      addr = 33'd1;
      for (int c = 0; c < 20; c++) begin
        v_def = (c % 4 == 0);
        r = {$urandom, $urandom};
        d_def = v_def ? addr : r[32:0];
        tick();
        if (v_def) begin
          m = ref_fold(m, {479'b0, addr}, 512, 33, LFSR_POLY_512);
          addr = addr + 33'd1;
        end
        if (pass == 0) exp_q[c] = m;
        checks++;
        if (crc_def !== exp_q[c]) begin
          errors++;
          $display("[TB] FAIL midstream_p%0d_c%0d: got %h expected %h", pass, c, crc_def, exp_q[c]);
        end
      end
      rst = 1'b1;
      v_def = 1'b1;
      d_def = addr;
      tick();
      rst = 1'b0;
      v_def = 1'b0;
      checks++;
      if (crc_def !== ONES512) begin
        errors++;
        $display("[TB] FAIL midstream_reset%0d: got %h expected %h", pass, crc_def, ONES512);
      end
    end
  endtask

  task automatic test_zero_lock();
    $display("[TB] test_zero_lock");
    do_reset();
    checks++;
    if (crc_zero !== 512'b0) begin
      errors++;
      $display("[TB] FAIL zero_reset: got %h expected 0", crc_zero);
    end
    for (int c = 0; c < 10; c++) begin
      d_zero = 1'b0;
      v_zero = 1'b1;
      tick();
      checks++;
      if (crc_zero !== 512'b0) begin
        errors++;
        $display("[TB] FAIL zero_hold%0d: got %h expected 0", c, crc_zero);
      end
    end
    d_zero = 1'b1;
    tick();
    v_zero = 1'b0;
    checks++;
    if (crc_zero !== LFSR_POLY_512) begin
      errors++;
      $display("[TB] FAIL zero_one: got %h expected %h", crc_zero, LFSR_POLY_512);
    end
  endtask

  initial begin
    d_def = '0; d_c32 = '0; d_c16 = '0; d_c32w = '0; d_zero = '0;
    idle_all();
    test_reset();
    test_crc32();
    test_crc16_bubbles();
    test_width_equiv();
    test_random_default();
    test_reset_midstream();
    test_zero_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
